// File: rtl/sad_wta_select.sv
// sad_wta_select: accumulates |left - right| over one NxN window per candidate
// disparity, then picks the lowest-SAD disparity (winner-take-all) for each
// output pixel. Pixel pairs arrive in window order from the BRAM sequencer.
module sad_wta_select #(
    parameter int NUM_OF_WIN = 64,
    parameter int PIX_W      = 8,
    parameter int SAD_W      = 14
) (
    input  logic             clka,
    input  logic             reset_n,
    input  logic             go,
    input  logic [2:0]       window,
    input  logic [17:0]      num_pix,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] left_pix,
    input  logic [PIX_W-1:0] right_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_disp,
    output logic [SAD_W-1:0] out_sad,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_DISP = 6'(NUM_OF_WIN - 1);

    state_t           state;
    state_t           state_nxt;

    logic [5:0]       win_len;      // samples per window: 9, 25 or 49
    logic [17:0]      num_pix_r;
    logic [17:0]      pix_cnt;
    logic [17:0]      pix_inc;
    logic [5:0]       sample_cnt;
    logic [5:0]       disp_cnt;
    logic [5:0]       best_disp;
    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] best_sad;
    logic             done_r;
    logic             err_r;

    // Absolute difference of two unsigned pixels, formed as a signed
    // subtraction one bit wider than needed so the sign is never lost.
    function automatic logic [PIX_W:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
        logic signed [PIX_W+1:0] d;
        logic signed [PIX_W+1:0] m;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        m = (d < 0) ? -d : d;
        return m[PIX_W:0];
    endfunction

    // Only odd square windows 3x3, 5x5 and 7x7 are supported.
    function automatic logic window_legal(input logic [2:0] w);
        return (w == 3'b011) || (w == 3'b101) || (w == 3'b111);
    endfunction

    function automatic logic [5:0] window_samples(input logic [2:0] w);
        logic [5:0] n;
        case (w)
            3'b011:  n = 6'd9;
            3'b101:  n = 6'd25;
            3'b111:  n = 6'd49;
            default: n = 6'd0;
        endcase
        return n;
    endfunction

    // Widen a pixel difference to accumulator width; 49*255 cannot overflow SAD_W.
    function automatic logic [SAD_W-1:0] acc_add(input logic [SAD_W-1:0] a,
                                                 input logic [PIX_W:0]   d);
        return a + {{(SAD_W-PIX_W-1){1'b0}}, d};
    endfunction

    assign pix_inc = pix_cnt + 18'd1;
    assign done    = done_r;
    assign err     = err_r;

    // State register.
    always_ff @(posedge clka) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake/result outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        out_disp  = '0;
        out_sad   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go && window_legal(window) && (num_pix != 18'd0)) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (sample_cnt == win_len - 6'd1)) begin
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                state_nxt = (disp_cnt == LAST_DISP) ? OUTPUT : ACCUM;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_disp  = best_disp;
                out_sad   = best_sad;
                if (out_ready) begin
                    state_nxt = (pix_inc == num_pix_r) ? IDLE : ACCUM;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, SAD accumulator, running minimum and status pulses.
    always_ff @(posedge clka) begin
        if (!reset_n) begin
            win_len    <= '0;
            num_pix_r  <= '0;
            pix_cnt    <= '0;
            sample_cnt <= '0;
            disp_cnt   <= '0;
            best_disp  <= '0;
            acc        <= '0;
            best_sad   <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (window_legal(window)) begin
                            win_len   <= window_samples(window);
                            num_pix_r <= num_pix;
                            if (num_pix == 18'd0) begin
                                done_r <= 1'b1;
                            end else begin
                                pix_cnt    <= '0;
                                sample_cnt <= '0;
                                disp_cnt   <= '0;
                                best_disp  <= '0;
                                acc        <= '0;
                                best_sad   <= '1;
                            end
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc        <= acc_add(acc, abs_diff(left_pix, right_pix));
                        sample_cnt <= sample_cnt + 6'd1;
                    end
                end
                COMPARE: begin
                    // Strict compare: on a tie the earlier (lower) disparity stays.
                    if (acc < best_sad) begin
                        best_sad  <= acc;
                        best_disp <= disp_cnt;
                    end
                    acc        <= '0;
                    sample_cnt <= '0;
                    if (disp_cnt != LAST_DISP) begin
                        disp_cnt <= disp_cnt + 6'd1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        pix_cnt  <= pix_inc;
                        disp_cnt <= '0;
                        best_sad <= '1;
                        if (pix_inc == num_pix_r) begin
                            done_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_wta_select.sv
// Testbench for sad_wta_select: randomized and patterned window data, a
// per-pixel SAD/winner-take-all reference model feeding a scoreboard, and an
// independent monitor that pops expected results on each output handshake.
module tb_sad_wta_select;

    localparam int NW = 64;
    localparam int PW = 8;
    localparam int SW = 14;

    logic          clka = 1'b0;
    logic          reset_n;
    logic          go;
    logic [2:0]    window;
    logic [17:0]   num_pix;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] left_pix;
    logic [PW-1:0] right_pix;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_disp;
    logic [SW-1:0] out_sad;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clka = ~clka;

    sad_wta_select #(.NUM_OF_WIN(NW), .PIX_W(PW), .SAD_W(SW)) dut (
        .clka(clka), .reset_n(reset_n), .go(go), .window(window), .num_pix(num_pix),
        .in_valid(in_valid), .in_ready(in_ready), .left_pix(left_pix), .right_pix(right_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_disp(out_disp), .out_sad(out_sad),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [31:0] disp;
        logic [31:0] sad;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cur_n  = 9;
    int   run_expected = 0;
    int   run_results  = 0;
    int   done_cycles  = 0;
    int   stall_left   = 0;
    bit   rand_ready   = 1'b0;
    int   last_disp    = -1;
    int   last_sad     = -1;
    int   lp[NW][49];
    int   rp[NW][49];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Fill the window data for one output pixel.
    // mode 0: pair (100, 100-(d^w)), so only d == w has zero SAD
    // mode 1: every pair (255, 0)
    // mode 2: uniformly random pixels
    task automatic build(input int mode, input int w);
        for (int d = 0; d < NW; d++) begin
            for (int k = 0; k < cur_n; k++) begin
                case (mode)
                    0: begin lp[d][k] = 100; rp[d][k] = 100 - (d ^ w); end
                    1: begin lp[d][k] = 255; rp[d][k] = 0; end
                    default: begin
                        lp[d][k] = int'($urandom_range(0, 255));
                        rp[d][k] = int'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    // Reference: SAD per disparity, lowest SAD wins, first one wins a tie.
    task automatic model_push();
        int   best;
        int   bd;
        exp_t e;
        best = 32'h7fff_ffff;
        bd   = 0;
        for (int d = 0; d < NW; d++) begin
            int s;
            s = 0;
            for (int k = 0; k < cur_n; k++) begin
                s += (lp[d][k] > rp[d][k]) ? lp[d][k] - rp[d][k] : rp[d][k] - lp[d][k];
            end
            if (s < best) begin
                best = s;
                bd   = d;
            end
        end
        e.disp = bd;
        e.sad  = best;
        sb.push_back(e);
    endtask

    task automatic send_beat(input int l, input int r, input bit rand_valid);
        bit ok;
        ok = 1'b0;
        if (rand_valid && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clka);
            #1;
        end
        left_pix  = PW'(l);
        right_pix = PW'(r);
        in_valid  = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clka);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_accept_timeout", 0, 1);
        @(posedge clka);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_pixel(input int ndisp, input int extra, input bit rand_valid);
        for (int d = 0; d < ndisp; d++) begin
            for (int k = 0; k < cur_n; k++) begin
                send_beat(lp[d][k], rp[d][k], rand_valid);
            end
        end
        for (int k = 0; k < extra; k++) begin
            send_beat(lp[ndisp][k], rp[ndisp][k], rand_valid);
        end
        if (ndisp == NW) begin
            @(negedge clka);
            check("latency_compare_cycle_out_valid", out_valid, 0);
            @(negedge clka);
            check("latency_output_cycle_out_valid", out_valid, 1);
        end
    endtask

    task automatic start_run(input logic [2:0] w, input int np, input int n);
        cur_n        = n;
        run_expected = np;
        run_results  = 0;
        window       = w;
        num_pix      = 18'(np);
        go           = 1'b1;
        @(posedge clka);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clka);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    // Result acceptance: random, or held low for stall_left cycles of out_valid.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clka);
            #1;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: in_ready gaps, output stability under stall, scoreboard, done.
    initial begin
        int   beats;
        bit   stall_exp;
        bit   have_prev;
        int   prev_disp;
        int   prev_sad;
        exp_t e;
        beats = 0; stall_exp = 0; have_prev = 0; prev_disp = 0; prev_sad = 0;
        forever begin
            @(negedge clka);
            if (!reset_n) begin
                beats = 0; stall_exp = 0; have_prev = 0;
            end else begin
                if (stall_exp) begin
                    check("in_ready_low_in_compare", in_ready, 0);
                    stall_exp = 0;
                end
                if (in_valid && in_ready) begin
                    beats++;
                    if (beats == cur_n) begin
                        beats = 0;
                        stall_exp = 1;
                    end
                end
                if (out_valid) begin
                    check("in_ready_low_in_output", in_ready, 0);
                    if (have_prev) begin
                        check("stall_disp_stable", out_disp, prev_disp);
                        check("stall_sad_stable", out_sad, prev_sad);
                    end
                    if (out_ready) begin
                        have_prev = 0;
                        if (sb.size() == 0) begin
                            check("unexpected_result", 0, 1);
                        end else begin
                            e = sb.pop_front();
                            check("out_disp", out_disp, e.disp);
                            check("out_sad", out_sad, e.sad);
                        end
                        last_disp = int'(out_disp);
                        last_sad  = int'(out_sad);
                        run_results++;
                    end else begin
                        have_prev = 1;
                        prev_disp = int'(out_disp);
                        prev_sad  = int'(out_sad);
                    end
                end else begin
                    have_prev = 0;
                end
                if (done) begin
                    done_cycles++;
                    check("done_after_last_result", run_results, run_expected);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_out_disp"}, out_disp, 0);
        check({tag, "_out_sad"}, out_sad, 0);
    endtask

    initial begin
        int d0;
        int saved_disp;
        int saved_sad;
        reset_n = 1'b0; go = 1'b0; window = 3'b011; num_pix = '0;
        in_valid = 1'b0; left_pix = '0; right_pix = '0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        check_all_zero("reset");
        @(posedge clka);
        #1;
        reset_n = 1'b1;

        // 1: 3x3, unique zero-SAD candidate at d=5
        d0 = done_cycles;
        start_run(3'b011, 1, 9);
        check("busy_after_go", busy, 1);
        build(0, 5);
        model_push();
        drive_pixel(NW, 0, 1'b0);
        wait_idle("t1_idle");
        check("t1_disp", last_disp, 5);
        check("t1_sad", last_sad, 0);
        check("t1_done_count", done_cycles - d0, 1);

        // 2: 7x7, all SADs at the maximum, tie keeps d=0
        start_run(3'b111, 1, 49);
        build(1, 0);
        model_push();
        drive_pixel(NW, 0, 1'b0);
        wait_idle("t2_idle");
        check("t2_disp", last_disp, 0);
        check("t2_sad", last_sad, 12495);

        // 3: 5x5 random data, first without stalls, then gappy input and 20-cycle stall
        build(2, 0);
        start_run(3'b101, 1, 25);
        model_push();
        drive_pixel(NW, 0, 1'b0);
        wait_idle("t3a_idle");
        saved_disp = last_disp;
        saved_sad  = last_sad;
        stall_left = 20;
        start_run(3'b101, 1, 25);
        model_push();
        drive_pixel(NW, 0, 1'b1);
        wait_idle("t3b_idle");
        check("t3_disp_same_as_unstalled", last_disp, saved_disp);
        check("t3_sad_same_as_unstalled", last_sad, saved_sad);

        // 4: illegal window, then num_pix == 0
        d0 = done_cycles;
        window = 3'b100; num_pix = 18'd1; go = 1'b1;
        @(posedge clka);
        #1;
        go = 1'b0;
        @(negedge clka);
        check("t4_err_pulse", err, 1);
        check("t4_err_busy", busy, 0);
        @(negedge clka);
        check("t4_err_one_cycle", err, 0);
        check("t4_err_still_idle", busy, 0);
        start_run(3'b011, 0, 9);
        @(negedge clka);
        check("t4_done_pulse", done, 1);
        check("t4_zero_busy", busy, 0);
        check("t4_zero_no_out_valid", out_valid, 0);
        @(negedge clka);
        check("t4_done_one_cycle", done, 0);
        check("t4_done_count", done_cycles - d0, 1);

        // 5: three pixels with winners 63, 0, 31 and random out_ready
        d0 = done_cycles;
        rand_ready = 1'b1;
        start_run(3'b011, 3, 9);
        build(0, 63); model_push(); drive_pixel(NW, 0, 1'b0);
        build(0, 0);  model_push(); drive_pixel(NW, 0, 1'b0);
        build(0, 31); model_push(); drive_pixel(NW, 0, 1'b0);
        wait_idle("t5_idle");
        rand_ready = 1'b0;
        check("t5_last_disp", last_disp, 31);
        check("t5_result_count", run_results, 3);
        check("t5_done_count", done_cycles - d0, 1);

        // 6: reset during ACCUM of disparity 10, then a clean run with winner d=2
        d0 = done_cycles;
        start_run(3'b011, 1, 9);
        build(2, 0);
        drive_pixel(10, 4, 1'b0);
        check("t6_busy_before_abort", busy, 1);
        reset_n = 1'b0;
        @(posedge clka);
        @(negedge clka);
        check_all_zero("abort");
        @(posedge clka);
        #1;
        reset_n = 1'b1;
        start_run(3'b011, 1, 9);
        build(0, 2);
        model_push();
        drive_pixel(NW, 0, 1'b0);
        wait_idle("t6_idle");
        check("t6_disp", last_disp, 2);
        check("t6_sad", last_sad, 0);
        check("t6_done_count", done_cycles - d0, 1);
        check("scoreboard_drained", sb.size(), 0);

        repeat (3) @(posedge clka);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sad_wta_select.md
Name: sad_wta_select

Overview:
- Downstream consumer of the BRAM window-address sequencer in the disparity-map pipeline.
- Receives left/right pixel pairs read from the dual-port BRAM in window order, one pair per beat.
- Accumulates a sum of absolute differences (SAD) over each 3x3, 5x5 or 7x7 window, one window per candidate disparity.
- After NUM_OF_WIN candidates, selects the minimum-SAD disparity (winner-take-all) and emits it for the current output pixel.

Parameters:
NUM_OF_WIN, 64, candidate disparities per output pixel (power of 2, <= 64)
PIX_W, 8, pixel width in bits
SAD_W, 14, accumulator width; 49*255 = 12495 fits without overflow

Ports:
clka  input  1  clock; all logic is on the rising edge
reset_n  input  1  synchronous, active-low reset
go  input  1  start request; sampled only in IDLE
window  input  3  window size: 3'b011, 3'b101 or 3'b111; latched on an accepted go
num_pix  input  18  number of output pixels to produce; latched on an accepted go
in_valid  input  1  pixel pair valid
in_ready  output  1  block accepts a pair this cycle
left_pix  input  PIX_W  left-image pixel
right_pix  input  PIX_W  right-image pixel
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_disp  output  6  winning disparity index
out_sad  output  SAD_W  winning SAD value
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last result handshake
err  output  1  one-cycle pulse when go arrives with an illegal window

Behaviour:
- Reset (reset_n == 0 at a clka edge): state goes to IDLE. All outputs read 0 except out_sad, which reads 0 in its registered form. All counters, the accumulator and best_sad clear. Reset mid-operation aborts immediately; a partial window or pixel is discarded and no done pulse is issued.
- States: IDLE, ACCUM, COMPARE, OUTPUT.
- IDLE:
  - go with a legal window: latch N = 9, 25 or 49 and latch num_pix.
    - num_pix == 0: pulse done next cycle and stay in IDLE.
    - Otherwise: clear sample_cnt, disp_cnt and acc, set best_sad to all-ones, then go to ACCUM.
  - go with any other window value: pulse err next cycle and stay in IDLE.
- ACCUM:
  - in_ready = 1.
  - On each in_valid && in_ready: acc <= acc + |left_pix - right_pix|, computed unsigned at PIX_W+1 bits and zero-extended; sample_cnt increments.
  - When the beat that makes sample_cnt == N is accepted, go to COMPARE on the next cycle.
  - Idle beats (in_valid = 0) do not advance anything.
- COMPARE (exactly 1 cycle, in_ready = 0):
  - If acc < best_sad (strict), then best_sad <= acc and best_disp <= disp_cnt. Ties keep the lower disparity.
  - acc and sample_cnt clear.
  - If disp_cnt == NUM_OF_WIN-1, go to OUTPUT. Otherwise disp_cnt increments and the state returns to ACCUM.
- OUTPUT:
  - out_valid = 1, with out_disp/out_sad = best_disp/best_sad, held stable until out_ready.
  - On the handshake:
    - pix_cnt increments, disp_cnt clears and best_sad resets to all-ones.
    - If pix_cnt reaches num_pix: go to IDLE and pulse done in the cycle after the handshake.
    - Otherwise: go to ACCUM.
  - If out_ready is already high on the first OUTPUT cycle, the result is accepted that same cycle.
- Latency: the last sample of the final window is accepted at cycle t. COMPARE runs at t+1 and out_valid rises at t+2.
- Throughput: a pixel with back-to-back input and no backpressure takes NUM_OF_WIN*(N+1) + 1 cycles.
- go, window and num_pix are ignored outside IDLE; window size is fixed for a whole run.

Test Plan:
1. window=3'b011, num_pix=1. Disparity d gets all pairs (100, 100-(d^5)); only d=5 gives 0. -> out_disp=5, out_sad=0, done pulses once, busy falls.
2. window=3'b111, all pairs (255, 0), num_pix=1. -> every SAD = 12495; tie keeps the first candidate, so out_disp=0 and out_sad=12495 with no overflow.
3. window=3'b101, in_valid toggled pseudo-randomly, out_ready held 0 for 20 cycles. -> in_ready is 0 in COMPARE and OUTPUT, the result stays stable while stalled, and the result is identical to the no-stall run.
4. window=3'b100, then window=3'b011 with num_pix=0. -> first go gives an err pulse and state stays IDLE; second go gives a done pulse, no out_valid, state stays IDLE.
5. num_pix=3, window=3'b011, minimum at disparities 63, 0 and 31 in turn. -> three results in order (63, 0, 31); done pulses after the third handshake only.
6. reset_n driven low during ACCUM of disparity 10, then a fresh go with a minimum at d=2. -> all outputs are 0 after reset, and the new result is 2 with no leakage from the aborted run.
